// File: rtl/pic_prio_core.sv
// Interrupt priority core: IMR/IRR/ISR, rotating or fixed priority, two-pulse INTA, EOI/AEOI.
// Optional poll command enabled by defining PIC_PRIO_POLL_EN.
module pic_prio_core #(
    parameter int NUM_IRQ = 8,
    parameter int IDX_W   = $clog2(NUM_IRQ),
    parameter int VEC_W   = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_IRQ-1:0]     irq_in,
    input  logic                   ltim,
    input  logic                   aeoi,
    input  logic                   rotate_en,
    input  logic [VEC_W-IDX_W-1:0] vec_base,
    input  logic                   imr_we,
    input  logic [NUM_IRQ-1:0]     imr_wdata,
    input  logic                   eoi_req,
    input  logic                   eoi_specific,
    input  logic [IDX_W-1:0]       eoi_idx,
    input  logic                   inta_n,
`ifdef PIC_PRIO_POLL_EN
    input  logic                   poll_req,
    output logic [7:0]             poll_word,
`endif
    output logic                   int_out,
    output logic [VEC_W-1:0]       vec_out,
    output logic                   vec_valid,
    output logic [NUM_IRQ-1:0]     imr,
    output logic [NUM_IRQ-1:0]     irr,
    output logic [NUM_IRQ-1:0]     isr
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_IRQ - 1);

    typedef enum logic [1:0] {IDLE, ACK1, ACK2} state_t;

    typedef struct packed {
        logic             found;
        logic [IDX_W-1:0] idx;
        logic [IDX_W-1:0] rank;   // 0 = highest priority
    } prio_t;

    state_t               state, state_n;
    logic [NUM_IRQ-1:0]   irq_prev;
    logic                 inta_q;
    logic [IDX_W-1:0]     ptr, ptr_n, sel;
    logic                 spurious;
    logic [NUM_IRQ-1:0]   irr_n, isr_n;
    logic [IDX_W-1:0]     eff_ptr;
    prio_t                cand, isr_hi;
    logic                 inta_fall, inta_rise;
    logic                 ack1_go, ack2_go, ack_done, take, int_n;

    // Scan starts just after the lowest-priority pointer and wraps.
    function automatic prio_t find_hi(input logic [NUM_IRQ-1:0] vec,
                                      input logic [IDX_W-1:0]   p);
        prio_t r;
        int    j;
        r = '0;
        for (int k = 0; k < NUM_IRQ; k++) begin
            j = (int'(p) + 1 + k) % NUM_IRQ;
            if (!r.found && vec[j]) begin
                r.found = 1'b1;
                r.idx   = IDX_W'(j);
                r.rank  = IDX_W'(k);
            end
        end
        return r;
    endfunction

    assign inta_fall = inta_q & ~inta_n;
    assign inta_rise = ~inta_q & inta_n;
    assign eff_ptr   = rotate_en ? ptr : LAST_IDX;
    assign cand      = find_hi(irr & ~imr, eff_ptr);
    assign isr_hi    = find_hi(isr, eff_ptr);

    // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_n  = state;
        ack1_go  = 1'b0;
        ack2_go  = 1'b0;
        ack_done = 1'b0;
        case (state)
            IDLE:    if (inta_fall) begin state_n = ACK1; ack1_go  = 1'b1; end
            ACK1:    if (inta_fall) begin state_n = ACK2; ack2_go  = 1'b1; end
            ACK2:    if (inta_rise) begin state_n = IDLE; ack_done = 1'b1; end
            default: state_n = IDLE;
        endcase

        take = ack1_go & cand.found;
`ifdef PIC_PRIO_POLL_EN
        if (poll_req && state == IDLE && !inta_fall && cand.found)
            take = 1'b1;
`endif

        irr_n = ltim ? irq_in : (irr | (irq_in & ~irq_prev));
        if (take)
            irr_n[cand.idx] = 1'b0;

        isr_n = isr;
        ptr_n = ptr;
        if (ack_done && aeoi && !spurious) begin
            isr_n[sel] = 1'b0;
            if (rotate_en) ptr_n = sel;
        end
        // EOI is applied after AEOI so that its index wins the pointer.
        if (eoi_req) begin
            if (eoi_specific) begin
                if (int'(eoi_idx) < NUM_IRQ) begin
                    isr_n[eoi_idx] = 1'b0;
                    if (rotate_en) ptr_n = eoi_idx;
                end
            end else if (isr_hi.found) begin
                isr_n[isr_hi.idx] = 1'b0;
                if (rotate_en) ptr_n = isr_hi.idx;
            end
        end
        if (take)
            isr_n[cand.idx] = 1'b1;

        int_n = cand.found && (!isr_hi.found || cand.rank < isr_hi.rank) && !take;
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from the same pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            imr       <= '0;
            irr       <= '0;
            isr       <= '0;
            irq_prev  <= '0;
            inta_q    <= 1'b1;
            ptr       <= LAST_IDX;
            sel       <= '0;
            spurious  <= 1'b0;
            int_out   <= 1'b0;
            vec_out   <= '0;
            vec_valid <= 1'b0;
`ifdef PIC_PRIO_POLL_EN
            poll_word <= '0;
`endif
        end else begin
            state    <= state_n;
            irr      <= irr_n;
            isr      <= isr_n;
            ptr      <= ptr_n;
            irq_prev <= irq_in;
            inta_q   <= inta_n;
            int_out  <= int_n;
            if (imr_we)
                imr <= imr_wdata;
            if (ack1_go) begin
                sel      <= cand.found ? cand.idx : LAST_IDX;
                spurious <= ~cand.found;
            end
            if (ack2_go) begin
                vec_out   <= {vec_base, sel};
                vec_valid <= 1'b1;
            end
            if (ack_done)
                vec_valid <= 1'b0;
`ifdef PIC_PRIO_POLL_EN
            if (poll_req)
                poll_word <= (state == IDLE && !inta_fall)
                           ? {cand.found, {(7 - IDX_W){1'b0}}, cand.idx} : 8'h00;
`endif
        end
    end

endmodule

// File: tb/tb_pic_prio_core.sv
// Self-checking bench for pic_prio_core: vectors checked through a scoreboard queue,
// register views checked inline per scenario.
module tb_pic_prio_core;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] irq_in = '0;
    logic       ltim = 1'b0, aeoi = 1'b0, rotate_en = 1'b0;
    logic [4:0] vec_base = 5'b01000;
    logic       imr_we = 1'b0;
    logic [7:0] imr_wdata = '0;
    logic       eoi_req = 1'b0, eoi_specific = 1'b0;
    logic [2:0] eoi_idx = '0;
    logic       inta_n = 1'b1;
    logic       int_out, vec_valid;
    logic [7:0] vec_out, imr, irr, isr;
`ifdef PIC_PRIO_POLL_EN
    logic       poll_req = 1'b0;
    logic [7:0] poll_word;
`endif

    int checks = 0;
    int failures = 0;
    logic [7:0] sb[$];
    logic       vv_prev = 1'b0;

    pic_prio_core #(.NUM_IRQ(8), .VEC_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .irq_in(irq_in), .ltim(ltim), .aeoi(aeoi),
        .rotate_en(rotate_en), .vec_base(vec_base), .imr_we(imr_we),
        .imr_wdata(imr_wdata), .eoi_req(eoi_req), .eoi_specific(eoi_specific),
        .eoi_idx(eoi_idx), .inta_n(inta_n),
`ifdef PIC_PRIO_POLL_EN
        .poll_req(poll_req), .poll_word(poll_word),
`endif
        .int_out(int_out), .vec_out(vec_out), .vec_valid(vec_valid),
        .imr(imr), .irr(irr), .isr(isr)
    );

    always #5 clk = ~clk;

    // Scoreboard consumer: each vec_valid rise pops one expected vector.
    always @(negedge clk) begin
        if (vec_valid && !vv_prev) begin
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL vec_unexpected got=%h exp=none", vec_out);
            end else begin
                logic [7:0] exp_v;
                exp_v = sb.pop_front();
                if (vec_out !== exp_v) begin
                    failures++;
                    $display("FAIL vec_out got=%h exp=%h", vec_out, exp_v);
                end
            end
        end
        vv_prev = vec_valid;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0; irq_in = '0; inta_n = 1'b1; eoi_req = 1'b0; imr_we = 1'b0;
        wait_cycles(2);
        rst_n = 1'b1;
        wait_cycles(1);
    endtask

    task automatic pulse_irq(input logic [7:0] m);
        irq_in = m;
        wait_cycles(1);
        irq_in = '0;
        wait_cycles(2);
    endtask

    task automatic inta_pulse(input int low_cycles);
        inta_n = 1'b0;
        wait_cycles(low_cycles);
        inta_n = 1'b1;
        wait_cycles(2);
    endtask

    task automatic eoi(input logic spec, input logic [2:0] idx);
        eoi_req = 1'b1; eoi_specific = spec; eoi_idx = idx;
        wait_cycles(1);
        eoi_req = 1'b0;
        wait_cycles(1);
    endtask

    task automatic do_ack(input logic [7:0] exp_v);
        inta_pulse(2);
        sb.push_back(exp_v);
        inta_pulse(3);
        checks++;
        if (sb.size() != 0 || vec_valid !== 1'b0) begin
            failures++;
            $display("FAIL ack_done pending=%0d vec_valid=%b exp=0/0", sb.size(), vec_valid);
            sb.delete();
        end
    endtask

    task automatic test_reset();
        apply_reset();
        checks++;
        if ({imr, irr, isr, vec_out} !== 32'h0 || int_out !== 1'b0 || vec_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset got=%h/%h/%h/%h int=%b vv=%b exp=0", imr, irr, isr, vec_out, int_out, vec_valid);
        end
    endtask

    task automatic test_edge_fixed();
        ltim = 1'b0; aeoi = 1'b0; rotate_en = 1'b0;
        pulse_irq(8'h08);
        pulse_irq(8'h20);
        checks++;
        if (irr !== 8'h28 || int_out !== 1'b1) begin
            failures++;
            $display("FAIL edge_pending irr=%h int=%b exp=28/1", irr, int_out);
        end
        inta_pulse(2);
        checks++;
        if (isr !== 8'h08 || irr !== 8'h20) begin
            failures++;
            $display("FAIL ack1_regs isr=%h irr=%h exp=08/20", isr, irr);
        end
        sb.push_back(8'h43);
        inta_pulse(3);
        checks++;
        if (sb.size() != 0 || int_out !== 1'b0) begin
            failures++;
            $display("FAIL ack2_blocked pending=%0d int=%b exp=0/0", sb.size(), int_out);
            sb.delete();
        end
    endtask

    task automatic test_eoi_nonspecific();
        eoi(1'b0, 3'd0);
        checks++;
        if (isr !== 8'h00 || int_out !== 1'b1) begin
            failures++;
            $display("FAIL ns_eoi isr=%h int=%b exp=00/1", isr, int_out);
        end
        do_ack(8'h45);
        checks++;
        if (isr !== 8'h20 || irr !== 8'h00) begin
            failures++;
            $display("FAIL ns_eoi_ack isr=%h irr=%h exp=20/00", isr, irr);
        end
    endtask

    task automatic test_eoi_specific();
        apply_reset();
        pulse_irq(8'h20);
        do_ack(8'h45);
        pulse_irq(8'h08);
        checks++;
        if (int_out !== 1'b1) begin
            failures++;
            $display("FAIL nest_int got=%b exp=1", int_out);
        end
        do_ack(8'h43);
        checks++;
        if (isr !== 8'h28) begin
            failures++;
            $display("FAIL nest_isr got=%h exp=28", isr);
        end
        eoi(1'b1, 3'd5);
        checks++;
        if (isr !== 8'h08) begin
            failures++;
            $display("FAIL spec_eoi got=%h exp=08", isr);
        end
        eoi(1'b0, 3'd0);
        checks++;
        if (isr !== 8'h00) begin
            failures++;
            $display("FAIL ns_eoi_last got=%h exp=00", isr);
        end
    endtask

    task automatic test_aeoi_rotate();
        apply_reset();
        aeoi = 1'b1; rotate_en = 1'b1;
        pulse_irq(8'h44);
        do_ack(8'h42);
        checks++;
        if (isr !== 8'h00 || irr !== 8'h40) begin
            failures++;
            $display("FAIL aeoi_clear isr=%h irr=%h exp=00/40", isr, irr);
        end
        pulse_irq(8'h04);
        inta_pulse(2);
        checks++;
        if (isr !== 8'h40 || irr !== 8'h04) begin
            failures++;
            $display("FAIL rotate_sel isr=%h irr=%h exp=40/04", isr, irr);
        end
        sb.push_back(8'h46);
        inta_pulse(3);
        checks++;
        if (sb.size() != 0 || isr !== 8'h00) begin
            failures++;
            $display("FAIL rotate_ack2 pending=%0d isr=%h exp=0/00", sb.size(), isr);
            sb.delete();
        end
        aeoi = 1'b0; rotate_en = 1'b0;
    endtask

    task automatic test_level_spurious();
        apply_reset();
        ltim = 1'b1;
        irq_in = 8'h10;
        wait_cycles(2);
        checks++;
        if (irr !== 8'h10 || int_out !== 1'b1) begin
            failures++;
            $display("FAIL level_track irr=%h int=%b exp=10/1", irr, int_out);
        end
        irq_in = 8'h00;
        wait_cycles(2);
        do_ack(8'h47);
        checks++;
        if (isr !== 8'h00 || irr !== 8'h00) begin
            failures++;
            $display("FAIL spurious isr=%h irr=%h exp=00/00", isr, irr);
        end
        ltim = 1'b0;
    endtask

    task automatic test_mask_and_reset();
        int waited;
        apply_reset();
        imr_we = 1'b1; imr_wdata = 8'h01;
        wait_cycles(1);
        imr_we = 1'b0;
        pulse_irq(8'h01);
        checks++;
        if (imr !== 8'h01 || irr !== 8'h01 || int_out !== 1'b0) begin
            failures++;
            $display("FAIL masked imr=%h irr=%h int=%b exp=01/01/0", imr, irr, int_out);
        end
        imr_we = 1'b1; imr_wdata = 8'h00;
        wait_cycles(1);
        imr_we = 1'b0;
        wait_cycles(1);
        checks++;
        if (int_out !== 1'b1) begin
            failures++;
            $display("FAIL unmasked int=%b exp=1", int_out);
        end
        inta_pulse(2);
        sb.push_back(8'h40);
        inta_n = 1'b0;
        waited = 0;
        while (vec_valid !== 1'b1 && waited < 10) begin
            wait_cycles(1);
            waited++;
        end
        @(negedge clk);
        #1;
        checks++;
        if (vec_valid !== 1'b1 || sb.size() != 0) begin
            failures++;
            $display("FAIL ack2_entry vv=%b pending=%0d exp=1/0", vec_valid, sb.size());
            sb.delete();
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (vec_valid !== 1'b0 || {imr, irr, isr, vec_out} !== 32'h0 || int_out !== 1'b0) begin
            failures++;
            $display("FAIL midreset vv=%b regs=%h/%h/%h vec=%h int=%b exp=0", vec_valid, imr, irr, isr, vec_out, int_out);
        end
        wait_cycles(1);
        inta_n = 1'b1;
        rst_n = 1'b1;
        wait_cycles(1);
        pulse_irq(8'h01);
        inta_pulse(2);
        checks++;
        if (isr !== 8'h01 || vec_valid !== 1'b0) begin
            failures++;
            $display("FAIL lone_inta isr=%h vv=%b exp=01/0", isr, vec_valid);
        end
        sb.push_back(8'h40);
        inta_pulse(3);
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL lone_inta_ack2 pending=%0d exp=0", sb.size());
            sb.delete();
        end
    endtask

`ifdef PIC_PRIO_POLL_EN
    task automatic test_poll();
        apply_reset();
        pulse_irq(8'h02);
        poll_req = 1'b1;
        wait_cycles(1);
        poll_req = 1'b0;
        wait_cycles(1);
        checks++;
        if (poll_word !== 8'h81 || isr !== 8'h02 || irr !== 8'h00) begin
            failures++;
            $display("FAIL poll word=%h isr=%h irr=%h exp=81/02/00", poll_word, isr, irr);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_edge_fixed();
        test_eoi_nonspecific();
        test_eoi_specific();
        test_aeoi_rotate();
        test_level_spurious();
        test_mask_and_reset();
`ifdef PIC_PRIO_POLL_EN
        test_poll();
`endif
        wait_cycles(2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
